// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the memory-port arbiter, the fetch/memory pipeline
// stages and the unified memory model.
//   master : the arbiter (issues memory accesses, returns done pulses)
//   slave  : the environment (requesters plus memory)
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   // fetch requester
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_done;
   logic [DATA_W-1:0] if_rdata;
   // data-memory requester
   logic              d_req;
   logic              d_wr;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_done;
   logic [DATA_W-1:0] d_rdata;
   // unified memory port
   logic              mem_en;
   logic              mem_wr;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_done;
   logic              mem_createdump;

   modport master (
      input  if_req, if_addr,
      output if_done, if_rdata,
      input  d_req, d_wr, d_addr, d_wdata,
      output d_done, d_rdata,
      output mem_en, mem_wr, mem_addr, mem_wdata, mem_createdump,
      input  mem_rdata, mem_done
   );

   modport slave (
      output if_req, if_addr,
      input  if_done, if_rdata,
      output d_req, d_wr, d_addr, d_wdata,
      input  d_done, d_rdata,
      input  mem_en, mem_wr, mem_addr, mem_wdata, mem_createdump,
      output mem_rdata, mem_done
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Memory-port arbiter: shares the single-ported, variable-latency unified
// memory between instruction fetch and the data-memory stage, alternates
// grants under contention, times out a stuck memory, and on halt drains the
// outstanding access, fires one dump strobe and parks until reset.
module mem_port_arbiter #(
   parameter int ADDR_W   = 16,
   parameter int DATA_W   = 16,
   parameter int MAX_WAIT = 31
) (
   input  logic               clk,
   input  logic               rst_n,
   mem_port_arbiter_if.master bus,
   input  logic               halt,
   output logic               busy,
   output logic               halted,
   output logic               err
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      I_WAIT = 3'd1,
      D_WAIT = 3'd2,
      DUMP   = 3'd3,
      HALTED = 3'd4
   } state_t;

   localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

   state_t            r_state;
   state_t            w_state_nxt;

   logic              r_mem_en,     w_mem_en_nxt;
   logic              r_mem_wr,     w_mem_wr_nxt;
   logic [ADDR_W-1:0] r_mem_addr,   w_mem_addr_nxt;
   logic [DATA_W-1:0] r_mem_wdata,  w_mem_wdata_nxt;
   logic              r_dump,       w_dump_nxt;
   logic              r_if_done,    w_if_done_nxt;
   logic [DATA_W-1:0] r_if_rdata,   w_if_rdata_nxt;
   logic              r_d_done,     w_d_done_nxt;
   logic [DATA_W-1:0] r_d_rdata,    w_d_rdata_nxt;
   logic              r_busy,       w_busy_nxt;
   logic              r_halted,     w_halted_nxt;
   logic              r_err,        w_err_nxt;
   logic              r_last_d,     w_last_d_nxt;
   logic [7:0]        r_cnt,        w_cnt_nxt;
   logic              r_halt_pend;

   logic              w_if_elig;
   logic              w_d_elig;
   logic [7:0]        w_cnt_inc;

   // A requester whose done pulse is showing this cycle still holds its
   // level request; it must not be re-issued off that stale level.
   assign w_if_elig = bus.if_req & ~r_if_done;
   assign w_d_elig  = bus.d_req  & ~r_d_done;
   assign w_cnt_inc = r_cnt + 8'd1;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and next-output decode.
   always_comb begin
      w_state_nxt     = r_state;
      w_mem_en_nxt    = 1'b0;
      w_mem_wr_nxt    = r_mem_wr;
      w_mem_addr_nxt  = r_mem_addr;
      w_mem_wdata_nxt = r_mem_wdata;
      w_dump_nxt      = 1'b0;
      w_if_done_nxt   = 1'b0;
      w_if_rdata_nxt  = r_if_rdata;
      w_d_done_nxt    = 1'b0;
      w_d_rdata_nxt   = r_d_rdata;
      w_halted_nxt    = r_halted;
      w_err_nxt       = r_err;
      w_last_d_nxt    = r_last_d;
      w_cnt_nxt       = r_cnt;

      case (r_state)
         IDLE: begin
            if (r_halt_pend || halt) begin
               // halt beats any eligible request, and nothing is granted after it
               w_state_nxt = DUMP;
               w_dump_nxt  = 1'b1;
            end else if (w_d_elig && (!w_if_elig || !r_last_d)) begin
               w_state_nxt     = D_WAIT;
               w_mem_en_nxt    = 1'b1;
               w_mem_wr_nxt    = bus.d_wr;
               w_mem_addr_nxt  = bus.d_addr;
               w_mem_wdata_nxt = bus.d_wdata;
               w_cnt_nxt       = 8'd0;
               w_last_d_nxt    = 1'b1;
            end else if (w_if_elig) begin
               w_state_nxt     = I_WAIT;
               w_mem_en_nxt    = 1'b1;
               w_mem_wr_nxt    = 1'b0;
               w_mem_addr_nxt  = bus.if_addr;
               w_mem_wdata_nxt = {DATA_W{1'b0}};
               w_cnt_nxt       = 8'd0;
               w_last_d_nxt    = 1'b0;
            end else begin
               w_state_nxt = IDLE;
            end
         end

         I_WAIT, D_WAIT: begin
            // r_mem_en marks the issue cycle, where mem_done is not yet trusted
            if (bus.mem_done && !r_mem_en) begin
               w_state_nxt  = IDLE;
               w_mem_wr_nxt = 1'b0;
               if (r_state == D_WAIT) begin
                  w_d_done_nxt  = 1'b1;
                  w_d_rdata_nxt = r_mem_wr ? {DATA_W{1'b0}} : bus.mem_rdata;
               end else begin
                  w_if_done_nxt  = 1'b1;
                  w_if_rdata_nxt = bus.mem_rdata;
               end
            end else if (w_cnt_inc == MAX_WAIT_C) begin
               // stuck memory: release the requester with zero data, flag it
               w_state_nxt  = IDLE;
               w_mem_wr_nxt = 1'b0;
               w_err_nxt    = 1'b1;
               if (r_state == D_WAIT) begin
                  w_d_done_nxt  = 1'b1;
                  w_d_rdata_nxt = {DATA_W{1'b0}};
               end else begin
                  w_if_done_nxt  = 1'b1;
                  w_if_rdata_nxt = {DATA_W{1'b0}};
               end
            end else begin
               w_cnt_nxt = w_cnt_inc;
            end
         end

         DUMP: begin
            w_state_nxt  = HALTED;
            w_halted_nxt = 1'b1;
         end

         HALTED: begin
            w_state_nxt = HALTED;
         end

         default: begin
            w_state_nxt = IDLE;
         end
      endcase

      w_busy_nxt = (w_state_nxt == I_WAIT) || (w_state_nxt == D_WAIT);
   end

   // Output, datapath and bookkeeping registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem_en    <= 1'b0;
         r_mem_wr    <= 1'b0;
         r_mem_addr  <= {ADDR_W{1'b0}};
         r_mem_wdata <= {DATA_W{1'b0}};
         r_dump      <= 1'b0;
         r_if_done   <= 1'b0;
         r_if_rdata  <= {DATA_W{1'b0}};
         r_d_done    <= 1'b0;
         r_d_rdata   <= {DATA_W{1'b0}};
         r_busy      <= 1'b0;
         r_halted    <= 1'b0;
         r_err       <= 1'b0;
         r_last_d    <= 1'b0;
         r_cnt       <= 8'd0;
         r_halt_pend <= 1'b0;
      end else begin
         r_mem_en    <= w_mem_en_nxt;
         r_mem_wr    <= w_mem_wr_nxt;
         r_mem_addr  <= w_mem_addr_nxt;
         r_mem_wdata <= w_mem_wdata_nxt;
         r_dump      <= w_dump_nxt;
         r_if_done   <= w_if_done_nxt;
         r_if_rdata  <= w_if_rdata_nxt;
         r_d_done    <= w_d_done_nxt;
         r_d_rdata   <= w_d_rdata_nxt;
         r_busy      <= w_busy_nxt;
         r_halted    <= w_halted_nxt;
         r_err       <= w_err_nxt;
         r_last_d    <= w_last_d_nxt;
         r_cnt       <= w_cnt_nxt;
         r_halt_pend <= r_halt_pend | halt;
      end
   end

   assign bus.mem_en         = r_mem_en;
   assign bus.mem_wr         = r_mem_wr;
   assign bus.mem_addr       = r_mem_addr;
   assign bus.mem_wdata      = r_mem_wdata;
   assign bus.mem_createdump = r_dump;
   assign bus.if_done        = r_if_done;
   assign bus.if_rdata       = r_if_rdata;
   assign bus.d_done         = r_d_done;
   assign bus.d_rdata        = r_d_rdata;
   assign busy               = r_busy;
   assign halted             = r_halted;
   assign err                = r_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. The bench plays both requesters and
// the memory; every expected value below is worked out by hand from the
// cycle timing (req in cycle 0, mem_en cycle 1, done pulse one cycle after
// the accepted mem_done).
module tb_mem_port_arbiter;
   localparam int ADDR_W   = 16;
   localparam int DATA_W   = 16;
   localparam int MAX_WAIT = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic halt  = 1'b0;
   logic busy;
   logic halted;
   logic err;

   int n_vec = 0;
   int n_err = 0;

   mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   mem_port_arbiter #(
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .MAX_WAIT(MAX_WAIT)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus),
      .halt  (halt),
      .busy  (busy),
      .halted(halted),
      .err   (err)
   );

   always #5 clk = ~clk;

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic strobes(input string tag, input logic e_en, input logic e_if, input logic e_d);
      chk1({tag, " mem_en"},  bus.mem_en,  e_en);
      chk1({tag, " if_done"}, bus.if_done, e_if);
      chk1({tag, " d_done"},  bus.d_done,  e_d);
   endtask

   task automatic chk_zero(input string tag);
      chk1 ({tag, " mem_en"},    bus.mem_en,         1'b0);
      chk1 ({tag, " mem_wr"},    bus.mem_wr,         1'b0);
      chk16({tag, " mem_addr"},  bus.mem_addr,       16'h0000);
      chk16({tag, " mem_wdata"}, bus.mem_wdata,      16'h0000);
      chk1 ({tag, " dump"},      bus.mem_createdump, 1'b0);
      chk1 ({tag, " if_done"},   bus.if_done,        1'b0);
      chk16({tag, " if_rdata"},  bus.if_rdata,       16'h0000);
      chk1 ({tag, " d_done"},    bus.d_done,         1'b0);
      chk16({tag, " d_rdata"},   bus.d_rdata,        16'h0000);
      chk1 ({tag, " busy"},      busy,               1'b0);
      chk1 ({tag, " halted"},    halted,             1'b0);
      chk1 ({tag, " err"},       err,                1'b0);
   endtask

   // Hard stop if the directed sequence ever stalls.
   initial begin
      #100000;
      $display("FAIL watchdog: sequence did not finish, observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.if_req    = 1'b1;
      bus.if_addr   = 16'h0100;
      bus.d_req     = 1'b1;
      bus.d_wr      = 1'b0;
      bus.d_addr    = 16'h0200;
      bus.d_wdata   = 16'h0000;
      bus.mem_rdata = 16'h0000;
      bus.mem_done  = 1'b0;

      // ---- reset state, both requests already held ----
      step();
      step();
      chk_zero("reset");
      rst_n = 1'b1;

      // ---- contention: d, if, d, if with 1-cycle memory latency ----
      step(); strobes("ct1", 1'b1, 1'b0, 1'b0);
      chk16("ct1 addr", bus.mem_addr, 16'h0200);
      chk1 ("ct1 wr",   bus.mem_wr,   1'b0);
      chk1 ("ct1 busy", busy,         1'b1);
      step(); strobes("ct2", 1'b0, 1'b0, 1'b0);
      bus.mem_done = 1'b1; bus.mem_rdata = 16'hD001;
      step(); bus.mem_done = 1'b0;
      strobes("ct3", 1'b0, 1'b0, 1'b1);
      chk16("ct3 d_rdata", bus.d_rdata, 16'hD001);
      step(); strobes("ct4", 1'b1, 1'b0, 1'b0);
      chk16("ct4 addr", bus.mem_addr, 16'h0100);
      step(); strobes("ct5", 1'b0, 1'b0, 1'b0);
      bus.mem_done = 1'b1; bus.mem_rdata = 16'h1001;
      step(); bus.mem_done = 1'b0;
      strobes("ct6", 1'b0, 1'b1, 1'b0);
      chk16("ct6 if_rdata", bus.if_rdata, 16'h1001);
      step(); strobes("ct7", 1'b1, 1'b0, 1'b0);
      chk16("ct7 addr", bus.mem_addr, 16'h0200);
      step(); strobes("ct8", 1'b0, 1'b0, 1'b0);
      bus.mem_done = 1'b1; bus.mem_rdata = 16'hD002;
      step(); bus.mem_done = 1'b0;
      strobes("ct9", 1'b0, 1'b0, 1'b1);
      chk16("ct9 d_rdata", bus.d_rdata, 16'hD002);
      step(); strobes("ct10", 1'b1, 1'b0, 1'b0);
      chk16("ct10 addr", bus.mem_addr, 16'h0100);
      step(); strobes("ct11", 1'b0, 1'b0, 1'b0);
      bus.mem_done = 1'b1; bus.mem_rdata = 16'h1002;
      step(); bus.mem_done = 1'b0;
      strobes("ct12", 1'b0, 1'b1, 1'b0);
      chk16("ct12 if_rdata", bus.if_rdata, 16'h1002);
      bus.if_req = 1'b0; bus.d_req = 1'b0;
      step(); strobes("ct13", 1'b0, 1'b0, 1'b0);
      chk1("ct13 busy", busy, 1'b0);

      // ---- single load, mem_done two cycles after mem_en ----
      bus.d_req = 1'b1; bus.d_wr = 1'b0; bus.d_addr = 16'h0040;
      step(); strobes("ld1", 1'b1, 1'b0, 1'b0);
      chk16("ld1 addr", bus.mem_addr, 16'h0040);
      chk1 ("ld1 wr",   bus.mem_wr,   1'b0);
      step(); strobes("ld2", 1'b0, 1'b0, 1'b0);
      step(); strobes("ld3", 1'b0, 1'b0, 1'b0);
      chk1("ld3 busy", busy, 1'b1);
      bus.mem_done = 1'b1; bus.mem_rdata = 16'hBEEF;
      step(); bus.mem_done = 1'b0;
      strobes("ld4", 1'b0, 1'b0, 1'b1);
      chk16("ld4 d_rdata", bus.d_rdata, 16'hBEEF);
      chk1 ("ld4 busy",    busy,        1'b0);
      bus.d_req = 1'b0;
      step(); strobes("ld5", 1'b0, 1'b0, 1'b0);

      // ---- store; fetch raised mid-access must wait ----
      bus.d_req = 1'b1; bus.d_wr = 1'b1; bus.d_addr = 16'h0010; bus.d_wdata = 16'h1234;
      step(); strobes("st1", 1'b1, 1'b0, 1'b0);
      chk1 ("st1 wr",    bus.mem_wr,    1'b1);
      chk16("st1 addr",  bus.mem_addr,  16'h0010);
      chk16("st1 wdata", bus.mem_wdata, 16'h1234);
      bus.if_req = 1'b1; bus.if_addr = 16'h0300;
      step(); strobes("st2", 1'b0, 1'b0, 1'b0);
      chk1 ("st2 wr",    bus.mem_wr,    1'b1);
      chk16("st2 addr",  bus.mem_addr,  16'h0010);
      chk16("st2 wdata", bus.mem_wdata, 16'h1234);
      step(); strobes("st3", 1'b0, 1'b0, 1'b0);
      chk16("st3 wdata", bus.mem_wdata, 16'h1234);
      bus.mem_done = 1'b1; bus.mem_rdata = 16'hFFFF;
      step(); bus.mem_done = 1'b0;
      strobes("st4", 1'b0, 1'b0, 1'b1);
      chk16("st4 d_rdata", bus.d_rdata, 16'h0000);
      bus.d_req = 1'b0; bus.d_wr = 1'b0;
      step(); strobes("st5", 1'b1, 1'b0, 1'b0);
      chk16("st5 addr",  bus.mem_addr,  16'h0300);
      chk1 ("st5 wr",    bus.mem_wr,    1'b0);
      chk16("st5 wdata", bus.mem_wdata, 16'h0000);
      bus.mem_done = 1'b1; bus.mem_rdata = 16'hDEAD;   // issue cycle: must be ignored
      step(); strobes("st6", 1'b0, 1'b0, 1'b0);
      chk1("st6 busy", busy, 1'b1);
      bus.mem_rdata = 16'h5A5A;
      step(); bus.mem_done = 1'b0;
      strobes("st7", 1'b0, 1'b1, 1'b0);
      chk16("st7 if_rdata", bus.if_rdata, 16'h5A5A);
      bus.if_req = 1'b0;
      step(); strobes("st8", 1'b0, 1'b0, 1'b0);

      // ---- timeout: fetch never answered, MAX_WAIT = 4 ----
      bus.if_req = 1'b1; bus.if_addr = 16'h0400;
      step(); strobes("to1", 1'b1, 1'b0, 1'b0);
      step(); strobes("to2", 1'b0, 1'b0, 1'b0);
      step(); strobes("to3", 1'b0, 1'b0, 1'b0);
      step(); strobes("to4", 1'b0, 1'b0, 1'b0);
      chk1("to4 err", err, 1'b0);
      step(); strobes("to5", 1'b0, 1'b1, 1'b0);
      chk16("to5 if_rdata", bus.if_rdata, 16'h0000);
      chk1 ("to5 err",      err,          1'b1);
      chk1 ("to5 busy",     busy,         1'b0);
      bus.if_req = 1'b0;
      bus.d_req = 1'b1; bus.d_wr = 1'b0; bus.d_addr = 16'h0050;
      step(); strobes("to6", 1'b1, 1'b0, 1'b0);
      chk16("to6 addr", bus.mem_addr, 16'h0050);
      step(); strobes("to7", 1'b0, 1'b0, 1'b0);
      bus.mem_done = 1'b1; bus.mem_rdata = 16'h0A0A;
      step(); bus.mem_done = 1'b0;
      strobes("to8", 1'b0, 1'b0, 1'b1);
      chk16("to8 d_rdata", bus.d_rdata, 16'h0A0A);
      chk1 ("to8 err",     err,         1'b1);
      bus.d_req = 1'b0;

      // ---- reset in the middle of a store ----
      step();
      bus.d_req = 1'b1; bus.d_wr = 1'b1; bus.d_addr = 16'h0060; bus.d_wdata = 16'h7777;
      step(); strobes("rs1", 1'b1, 1'b0, 1'b0);
      chk1("rs1 wr", bus.mem_wr, 1'b1);
      step(); strobes("rs2", 1'b0, 1'b0, 1'b0);
      chk1("rs2 busy", busy, 1'b1);
      #2 rst_n = 1'b0;
      #1 chk_zero("rs_async");
      bus.d_req = 1'b0; bus.d_wr = 1'b0;
      bus.if_req = 1'b1; bus.if_addr = 16'h0700;
      step(); chk_zero("rs_held");
      rst_n = 1'b1;
      step(); strobes("rs3", 1'b1, 1'b0, 1'b0);
      chk16("rs3 addr", bus.mem_addr, 16'h0700);
      step(); strobes("rs4", 1'b0, 1'b0, 1'b0);
      bus.mem_done = 1'b1; bus.mem_rdata = 16'h0707;
      step(); bus.mem_done = 1'b0;
      strobes("rs5", 1'b0, 1'b1, 1'b0);
      chk16("rs5 if_rdata", bus.if_rdata, 16'h0707);
      bus.if_req = 1'b0;
      step(); strobes("rs6", 1'b0, 1'b0, 1'b0);

      // ---- halt during a fetch with a load pending ----
      bus.if_req = 1'b1; bus.if_addr = 16'h0800;
      step(); strobes("ht1", 1'b1, 1'b0, 1'b0);
      chk16("ht1 addr", bus.mem_addr, 16'h0800);
      bus.d_req = 1'b1; bus.d_wr = 1'b0; bus.d_addr = 16'h0900;
      step(); strobes("ht2", 1'b0, 1'b0, 1'b0);
      halt = 1'b1;
      bus.mem_done = 1'b1; bus.mem_rdata = 16'h0808;
      step(); halt = 1'b0; bus.mem_done = 1'b0;
      strobes("ht3", 1'b0, 1'b1, 1'b0);
      chk16("ht3 if_rdata", bus.if_rdata,       16'h0808);
      chk1 ("ht3 dump",     bus.mem_createdump, 1'b0);
      chk1 ("ht3 halted",   halted,             1'b0);
      bus.if_req = 1'b0;
      step(); strobes("ht4", 1'b0, 1'b0, 1'b0);
      chk1("ht4 dump",   bus.mem_createdump, 1'b1);
      chk1("ht4 halted", halted,             1'b0);
      chk1("ht4 busy",   busy,               1'b0);
      bus.mem_done = 1'b1;   // stray completion while parked
      for (int i = 0; i < 4; i++) begin
         step(); strobes("ht_park", 1'b0, 1'b0, 1'b0);
         chk1("ht_park dump",   bus.mem_createdump, 1'b0);
         chk1("ht_park halted", halted,             1'b1);
         chk1("ht_park busy",   busy,               1'b0);
      end
      bus.mem_done = 1'b0;
      bus.d_req = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences the single-ported, variable-latency unified memory and shares it between two requesters: instruction fetch (read-only) and the data-memory stage (LD/ST/STU).
- Drains outstanding traffic when the decoder's halt/dump indication fires, then issues the memory dump and parks.
- Also provides a stuck-memory timeout.
- Sits between the fetch/memory pipeline stages and the memory model.

Parameters:
ADDR_W, 16, address width
DATA_W, 16, data width
MAX_WAIT, 31, cycles after mem_en before a missing mem_done is declared a timeout (1..255)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous, active-low reset
if_req  in  1  fetch read request, level, held until if_done
if_addr  in  ADDR_W  fetch address, stable while if_req
if_done  out  1  one-cycle pulse, fetch complete
if_rdata  out  DATA_W  fetched word, valid with if_done
d_req  in  1  data request, level, held until d_done
d_wr  in  1  1=store, 0=load, stable while d_req
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_done  out  1  one-cycle pulse, data access complete
d_rdata  out  DATA_W  load data, valid with d_done
halt  in  1  halt/dump request from decode, level or pulse
mem_en  out  1  one-cycle issue strobe to memory
mem_wr  out  1  write qualifier, held for whole access
mem_addr  out  ADDR_W  held for whole access
mem_wdata  out  DATA_W  held for whole access
mem_rdata  in  DATA_W  read data, valid with mem_done
mem_done  in  1  access complete (read data valid)
mem_createdump  out  1  one-cycle dump strobe
busy  out  1  access outstanding (state I_WAIT or D_WAIT)
halted  out  1  sticky, arbiter parked after dump
err  out  1  sticky timeout flag

Behaviour:
- Reset:
  - Async on rst_n low: state IDLE, all outputs 0, halt_pend=0, last_d=0, counter 0.
  - Any in-flight access is abandoned; the memory is reset by the same rst_n.
- All outputs are registered.
- States: IDLE, I_WAIT, D_WAIT, DUMP, HALTED.
- halt_pend is set on any cycle halt=1 and is never cleared except by reset.
- IDLE, in priority order:
  - (1) halt_pend or halt -> DUMP.
  - (2) Both requesters eligible: d wins unless last_d=1, then fetch wins (anti-starvation alternation).
  - (3) Single eligible requester is granted.
  - On grant: latch addr/wr/wdata onto mem_*; mem_en=1 for the first WAIT cycle only; counter cleared; last_d <= (grant==d).
  - Fetch grant: mem_wr=0, mem_wdata=0.
- Eligibility: a requester whose done pulse is high in the current cycle is not eligible that cycle (prevents double issue on a held req).
- I_WAIT/D_WAIT:
  - mem_done is ignored in the mem_en cycle; it is sampled from the following cycle.
  - On mem_done: capture mem_rdata (loads and fetch; stores report rdata 0), pulse the matching *_done next cycle, -> IDLE.
  - Counter increments each WAIT cycle. When it reaches MAX_WAIT without mem_done: err<=1, matching *_done pulses with rdata 0, -> IDLE.
- Latency: req seen in IDLE at cycle 0 -> mem_en cycle 1 -> earliest mem_done cycle 2 -> *_done cycle 3 (minimum 3 cycles).
- Back-to-back issue: the earliest issue of the next access is the cycle after *_done.
- Halt mid-access: the access completes normally (including done pulse); the DUMP transition happens from the subsequent IDLE. Pending requests are never granted once halt_pend=1.
- DUMP: mem_createdump=1 for exactly one cycle -> HALTED.
- HALTED: halted=1; no grants, done pulses, or dumps until reset; requests are ignored.
- mem_done outside WAIT states is ignored.
- Simultaneous halt and grant-eligible requests in IDLE: halt wins.

Test Plan:
- Single load: d_req, d_addr=0x0040, mem_done 2 cycles after mem_en with mem_rdata=0xBEEF -> mem_en one cycle with mem_addr=0x0040, mem_wr=0; d_done pulse with d_rdata=0xBEEF, 4 cycles after req.
- Contention: if_req and d_req both held continuously from reset, each access 1-cycle latency -> grant order d, if, d, if; no requester starves; exactly one done per access.
- Store: d_wr=1, d_addr=0x0010, d_wdata=0x1234 -> mem_wr=1 and mem_addr/mem_wdata held until mem_done; d_done with d_rdata=0; no fetch issued while D_WAIT.
- Halt during fetch: halt pulse in cycle after mem_en of a fetch, d_req also pending -> fetch completes with if_done, then mem_createdump one cycle, halted=1, d_req never issued.
- Timeout: MAX_WAIT=4, fetch issued, mem_done never asserted -> after 4 WAIT cycles err=1 (sticky), if_done pulses with if_rdata=0, next request still serviced.
- Reset mid-access: rst_n low during D_WAIT -> all outputs 0 immediately; after release, a new if_req is serviced from IDLE and the abandoned d_done never appears.
